// File: rtl/data_mem_hs_if.sv
// Request/response bundle between the MEM stage and the handshaked data memory.
interface data_mem_hs_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_signed, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_signed, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_hs.sv
// Little-endian byte-lane data memory with one outstanding request, programmable
// wait states, address decode and error reporting on a held response.
module data_mem_hs #(
    parameter int unsigned MEMORY_SIZE_BYTES = 1024,
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int unsigned WAIT_STATES       = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_hs_if.slave  bus
);
    localparam int unsigned DEPTH = MEMORY_SIZE_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [1:0]        r_resp_err;
    logic              w_req_ready_nx;
    logic              w_resp_valid_nx;
    logic [31:0]       w_resp_rdata_nx;
    logic [1:0]        w_resp_err_nx;
    logic              w_cap;
    logic              w_access;

    logic [3:0][7:0]   r_mem [DEPTH];

    logic [31:0]       w_cur_addr;
    logic [31:0]       w_cur_wdata;
    logic              w_cur_we;
    logic [1:0]        w_cur_size;
    logic              w_cur_signed;
    logic [32:0]       w_off;
    logic              w_mis;
    logic              w_oor;
    logic [1:0]        w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic [3:0][7:0]   w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [3:0][7:0]   w_wlanes;
    logic              w_wr_en;

    // With zero wait states the access shares the accept edge, so decode live inputs in IDLE.
    assign w_cur_addr   = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
    assign w_cur_wdata  = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;
    assign w_cur_we     = (r_state == S_IDLE) ? bus.req_we     : r_we;
    assign w_cur_size   = (r_state == S_IDLE) ? bus.req_size   : r_size;
    assign w_cur_signed = (r_state == S_IDLE) ? bus.req_signed : r_signed;

    // 33-bit offset keeps addresses below the base from wrapping into range.
    assign w_off  = {1'b0, w_cur_addr} - {1'b0, BASE_ADDR};
    assign w_oor  = w_off[32] || (w_off[31:0] >= 32'(MEMORY_SIZE_BYTES));
    assign w_mis  = ((w_cur_size == 2'b01) && w_cur_addr[0]) ||
                    ((w_cur_size == 2'b10) && (w_cur_addr[1:0] != 2'b00));
    assign w_err  = (w_cur_size == 2'b11) ? 2'b11 :
                    w_mis                 ? 2'b01 :
                    w_oor                 ? 2'b10 : 2'b00;
    assign w_idx  = w_off[IDX_W+1:2];
    assign w_lane = w_off[1:0];
    assign w_word = r_mem[w_idx];

    // Load lane select and extension
    always_comb begin : load_fmt
        w_byte = w_word[w_lane];
        w_half = {w_word[{w_lane[1], 1'b1}], w_word[{w_lane[1], 1'b0}]};
        case (w_cur_size)
            2'b00:   w_load = {{24{w_cur_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{w_cur_signed & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin : store_fmt
        w_be     = 4'b0000;
        w_wlanes = w_cur_wdata;
        case (w_cur_size)
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{w_cur_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_cur_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wr_en = w_access && w_cur_we && (w_err == 2'b00);

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin : mem_wr
        if (w_wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) r_mem[w_idx][l] <= w_wlanes[l];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin : fsm_nx
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_cap           = 1'b0;
        w_access        = 1'b0;
        w_req_ready_nx  = r_req_ready;
        w_resp_valid_nx = r_resp_valid;
        w_resp_rdata_nx = r_resp_rdata;
        w_resp_err_nx   = r_resp_err;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_cap = 1'b1;
                    if (WAIT_STATES != 0) begin
                        w_state_nx     = S_WAIT;
                        w_cnt_nx       = CNT_LOAD;
                        w_req_ready_nx = 1'b0;
                    end else begin
                        w_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) w_access = 1'b1;
                else             w_cnt_nx = r_cnt - 1'b1;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nx      = S_IDLE;
                    w_req_ready_nx  = 1'b1;
                    w_resp_valid_nx = 1'b0;
                    w_resp_rdata_nx = '0;
                    w_resp_err_nx   = 2'b00;
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_req_ready_nx = 1'b1;
            end
        endcase
        if (w_access) begin
            w_state_nx      = S_RESP;
            w_req_ready_nx  = 1'b0;
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = w_err;
            w_resp_rdata_nx = ((w_err == 2'b00) && !w_cur_we) ? w_load : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 2'b00;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_req_ready  <= w_req_ready_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_rdata <= w_resp_rdata_nx;
            r_resp_err   <= w_resp_err_nx;
            if (w_cap) begin
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_we     <= bus.req_we;
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule
